// File: rtl/truth_table_pkg.sv
// Shared types and defaults for the truth-table checker.
package truth_table_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_IN_DEF = 3;
  localparam int HOLD_DEF = 20;
endpackage

// File: rtl/truth_table_checker_hold_timer.sv
// Loadable down-counter that paces how long each input vector is held.
module hold_timer
  import truth_table_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Parks at zero rather than wrapping, so the last hold leaves it idle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(HOLD_CYCLES - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector of a small combinational circuit, captures its
// output per vector and compares the resulting truth table to an expected one.
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  expected,
  output logic [N_IN-1:0]       vec_out,
  input  logic                  z_in,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(1<<N_IN)-1:0]  captured,
  output logic [N_IN:0]         mismatch_count,
  output logic                  first_fail_valid,
  output logic [N_IN-1:0]       first_fail_idx
);
  localparam int NV = 1 << N_IN;
  localparam int MW = N_IN + 1;

  state_t          state_q, state_d;
  logic [NV-1:0]   expected_q, expected_d;
  logic [NV-1:0]   captured_q, captured_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] first_fail_idx_q, first_fail_idx_d;
  logic [MW-1:0]   mismatch_count_q, mismatch_count_d;
  logic            first_fail_valid_q, first_fail_valid_d;
  logic            pass_q, pass_d;

  logic start_ok, sample, last_vec, miss, timer_load, timer_expire;

  assign start_ok   = start && (state_q != APPLY);
  assign sample     = (state_q == APPLY) && timer_expire;
  assign last_vec   = &vec_q;
  assign miss       = (z_in != expected_q[vec_q]);
  assign timer_load = start_ok || (sample && !last_vec);

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .en     (state_q == APPLY),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   if (sample && last_vec) state_d = DONE;
      DONE:    if (start) state_d = APPLY;
      default: state_d = IDLE;
    endcase
  end

  // Capture, compare and advance all happen on the edge that ends a hold.
  always_comb begin
    expected_d         = expected_q;
    captured_d         = captured_q;
    vec_d              = vec_q;
    mismatch_count_d   = mismatch_count_q;
    first_fail_valid_d = first_fail_valid_q;
    first_fail_idx_d   = first_fail_idx_q;
    pass_d             = pass_q;
    if (start_ok) begin
      expected_d         = expected;
      captured_d         = '0;
      vec_d              = '0;
      mismatch_count_d   = '0;
      first_fail_valid_d = 1'b0;
      first_fail_idx_d   = '0;
      pass_d             = 1'b0;
    end else if (sample) begin
      captured_d[vec_q] = z_in;
      if (miss) begin
        mismatch_count_d = mismatch_count_q + MW'(1);
        if (!first_fail_valid_q) begin
          first_fail_valid_d = 1'b1;
          first_fail_idx_d   = vec_q;
        end
      end
      if (last_vec) begin
        vec_d  = '0;
        pass_d = (mismatch_count_d == '0);
      end else begin
        vec_d = vec_q + N_IN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      captured_q         <= '0;
      vec_q              <= '0;
      mismatch_count_q   <= '0;
      first_fail_valid_q <= 1'b0;
      first_fail_idx_q   <= '0;
      pass_q             <= 1'b0;
    end else begin
      captured_q         <= captured_d;
      vec_q              <= vec_d;
      mismatch_count_q   <= mismatch_count_d;
      first_fail_valid_q <= first_fail_valid_d;
      first_fail_idx_q   <= first_fail_idx_d;
      pass_q             <= pass_d;
    end
  end

  // The expected table is only meaningful once latched by a start.
  always_ff @(posedge clk) begin
    expected_q <= expected_d;
  end

  always_comb begin
    busy             = (state_q == APPLY);
    done             = (state_q == DONE);
    vec_out          = vec_q;
    pass             = pass_q;
    captured         = captured_q;
    mismatch_count   = mismatch_count_q;
    first_fail_valid = first_fail_valid_q;
    first_fail_idx   = first_fail_idx_q;
  end
endmodule
